// File: rtl/gost28147_gamma_if.sv
// Handshake bundle for the GOST 28147-89 gamma wrapper: user side and core side.
// Optional GAMMA_PARTIAL_EN adds the din_nbytes byte count.
interface gost28147_gamma_if;
    logic [63:0] iv;
    logic        iv_load;
    logic        iv_ready;
    logic [63:0] din;
    logic        din_valid;
    logic        din_ready;
`ifdef GAMMA_PARTIAL_EN
    logic [2:0]  din_nbytes;
`endif
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        core_mode;
    logic [63:0] core_pdata;
    logic        core_pvalid;
    logic        core_pready;
    logic [63:0] core_cdata;
    logic        core_cvalid;
    logic        core_cready;

    modport slave (
`ifdef GAMMA_PARTIAL_EN
        input  din_nbytes,
`endif
        input  iv, iv_load, din, din_valid, dout_ready,
        input  core_pready, core_cdata, core_cvalid,
        output iv_ready, din_ready, dout, dout_valid,
        output core_mode, core_pdata, core_pvalid, core_cready
    );

    modport master (
`ifdef GAMMA_PARTIAL_EN
        output din_nbytes,
`endif
        output iv, iv_load, din, din_valid, dout_ready,
        output core_pready, core_cdata, core_cvalid,
        input  iv_ready, din_ready, dout, dout_valid,
        input  core_mode, core_pdata, core_pvalid, core_cready
    );
endinterface

// File: rtl/gost28147_gamma.sv
// GOST 28147-89 gamma (counter mode) wrapper around the gost28147 core.
// Define GAMMA_PARTIAL_EN to enable partial last-block output (din_nbytes).
module gost28147_gamma (
    input logic             clk,
    input logic             rst_n,
    gost28147_gamma_if.slave bus
);
    localparam logic [31:0] C1 = 32'h01010104;
    localparam logic [31:0] C2 = 32'h01010101;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INIT_REQ  = 3'd1;
    localparam logic [2:0] INIT_WAIT = 3'd2;
    localparam logic [2:0] STEP      = 3'd3;
    localparam logic [2:0] GAM_REQ   = 3'd4;
    localparam logic [2:0] GAM_WAIT  = 3'd5;
    localparam logic [2:0] GAM_READY = 3'd6;
    localparam logic [2:0] OUT       = 3'd7;

    logic [2:0]  state;
    logic [31:0] n3, n4;
    logic [63:0] gamma;
    logic [63:0] dout_q;
    logic        dvalid_q;
    logic [63:0] pdata_q;
    logic        pvalid_q;

    logic        iv_acc, din_acc, res_acc;
    logic [31:0] n3_nx, n4_nx;
    logic [32:0] n4_sum;
    logic [63:0] dmask;

    assign bus.iv_ready    = (state == IDLE) || (state == GAM_READY);
    assign iv_acc          = bus.iv_load && bus.iv_ready;
    // a simultaneous iv_load wins, so din is not offered in that cycle
    assign bus.din_ready   = (state == GAM_READY) && !bus.iv_load;
    assign din_acc         = bus.din_valid && bus.din_ready;
    assign bus.core_cready = (state == INIT_WAIT) || (state == GAM_WAIT);
    assign res_acc         = bus.core_cvalid && bus.core_cready;

    assign bus.core_mode   = 1'b0;
    assign bus.core_pdata  = pdata_q;
    assign bus.core_pvalid = pvalid_q;
    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dvalid_q;

    // N4 is added modulo 2^32-1: carry out wraps back in at bit 0
    assign n3_nx  = n3 + C2;
    assign n4_sum = {1'b0, n4} + {1'b0, C1};
    assign n4_nx  = n4_sum[31:0] + {31'd0, n4_sum[32]};

`ifdef GAMMA_PARTIAL_EN
    always_comb begin
        dmask = '0;
        for (int i = 0; i < 8; i++) begin
            if (bus.din_nbytes == 3'd0 || i < int'(bus.din_nbytes))
                dmask[i*8 +: 8] = 8'hFF;
        end
    end
`else
    assign dmask = '1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            n3       <= '0;
            n4       <= '0;
            gamma    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            pdata_q  <= '0;
            pvalid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iv_acc) begin
                        pdata_q  <= bus.iv;
                        pvalid_q <= 1'b1;
                        state    <= INIT_REQ;
                    end
                end
                INIT_REQ: begin
                    if (bus.core_pready) begin
                        pvalid_q <= 1'b0;
                        state    <= INIT_WAIT;
                    end
                end
                INIT_WAIT: begin
                    if (res_acc) begin
                        n4    <= bus.core_cdata[63:32];
                        n3    <= bus.core_cdata[31:0];
                        state <= STEP;
                    end
                end
                STEP: begin
                    n3       <= n3_nx;
                    n4       <= n4_nx;
                    pdata_q  <= {n4_nx, n3_nx};
                    pvalid_q <= 1'b1;
                    state    <= GAM_REQ;
                end
                GAM_REQ: begin
                    if (bus.core_pready) begin
                        pvalid_q <= 1'b0;
                        state    <= GAM_WAIT;
                    end
                end
                GAM_WAIT: begin
                    if (res_acc) begin
                        gamma <= bus.core_cdata;
                        state <= GAM_READY;
                    end
                end
                GAM_READY: begin
                    if (iv_acc) begin
                        pdata_q  <= bus.iv;
                        pvalid_q <= 1'b1;
                        state    <= INIT_REQ;
                    end else if (din_acc) begin
                        dout_q   <= (bus.din ^ gamma) & dmask;
                        dvalid_q <= 1'b1;
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (bus.dout_ready) begin
                        dvalid_q <= 1'b0;
                        state    <= STEP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gost28147_gamma.sv
// Self-checking bench for gost28147_gamma with a stub core E(x) = x ^ ekey.
// Counter arithmetic is recomputed from the mod 2^32 / mod 2^32-1 rules.
module tb_gost28147_gamma;
    localparam logic [31:0] C1 = 32'h01010104;
    localparam logic [31:0] C2 = 32'h01010101;

    logic clk;
    logic rst_n;

    gost28147_gamma_if bus ();

    gost28147_gamma dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    logic [63:0] ekey = '0;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          pr_always = 1'b1;
    bit          inject = 1'b0;

    logic [63:0] reqs[$];
    logic [63:0] exp_reqs[$];
    logic [63:0] ovr[$];
    logic [63:0] m_ovr[$];

    logic [31:0] m_n3, m_n4;
    logic [63:0] m_gamma;
    logic [63:0] last_req;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] add_c1(input logic [31:0] a);
        longint s;
        s = longint'({32'd0, a}) + longint'({32'd0, C1});
        if (s >= 64'h1_0000_0000) s = s - 64'hFFFF_FFFF;
        return s[31:0];
    endfunction

    function automatic logic [63:0] m_mask(input logic [2:0] nb);
        int n;
        n = (nb == 3'd0) ? 8 : int'(nb);
`ifndef GAMMA_PARTIAL_EN
        n = 8;
`endif
        if (n == 8) return '1;
        return (64'd1 << (8 * n)) - 64'd1;
    endfunction

    task automatic m_resp(input logic [63:0] x, output logic [63:0] r);
        if (m_ovr.size() > 0) r = m_ovr.pop_front();
        else r = x ^ ekey;
    endtask

    task automatic m_step();
        m_n3 = m_n3 + C2;
        m_n4 = add_c1(m_n4);
        exp_reqs.push_back({m_n4, m_n3});
        m_resp({m_n4, m_n3}, m_gamma);
    endtask

    task automatic m_load(input logic [63:0] v);
        logic [63:0] r;
        exp_reqs.push_back(v);
        m_resp(v, r);
        m_n4 = r[63:32];
        m_n3 = r[31:0];
        m_step();
    endtask

    task automatic push_ovr(input logic [63:0] v);
        ovr.push_back(v);
        m_ovr.push_back(v);
    endtask

    task automatic clear_all();
        reqs.delete();
        exp_reqs.delete();
        ovr.delete();
        m_ovr.delete();
    endtask

    // ---------------- stub core ----------------
    int          ph = 0;
    int          slat = 0;
    logic [63:0] sreq;

    initial begin
        bus.core_pready = 1'b0;
        bus.core_cvalid = 1'b0;
        bus.core_cdata  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.core_pready = 1'b0;
                bus.core_cvalid = 1'b0;
                ph = 0;
            end else if (inject) begin
                bus.core_pready = 1'b0;
                bus.core_cvalid = 1'b1;
                bus.core_cdata  = {$urandom, $urandom};
            end else begin
                case (ph)
                    0: begin
                        bus.core_cvalid = 1'b0;
                        bus.core_pready = pr_always ? 1'b1 :
                                          ($urandom_range(0, 1) == 1);
                        if (bus.core_pvalid && bus.core_pready) begin
                            sreq = bus.core_pdata;
                            reqs.push_back(sreq);
                            slat = $urandom_range(lat_max, lat_min);
                            ph = 1;
                        end
                    end
                    1: begin
                        bus.core_pready = 1'b0;
                        if (slat == 0) begin
                            bus.core_cvalid = 1'b1;
                            if (ovr.size() > 0) bus.core_cdata = ovr.pop_front();
                            else bus.core_cdata = sreq ^ ekey;
                            ph = bus.core_cready ? 3 : 2;
                        end else begin
                            slat--;
                        end
                    end
                    2: if (bus.core_cready) ph = 3;
                    default: begin
                        bus.core_cvalid = 1'b0;
                        ph = 0;
                    end
                endcase
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_reqs(input string tag);
        check({tag, "_nreq"}, 64'(reqs.size()), 64'(exp_reqs.size()));
        while (reqs.size() > 0 && exp_reqs.size() > 0) begin
            last_req = reqs.pop_front();
            check({tag, "_req"}, last_req, exp_reqs.pop_front());
        end
        reqs.delete();
        exp_reqs.delete();
    endtask

    task automatic wait_din_ready(input string tag, output int cyc);
        cyc = 0;
        while (!bus.din_ready && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check1({tag, "_din_ready"}, bus.din_ready, 1'b1);
    endtask

    task automatic do_load(input logic [63:0] v, output int cyc);
        int n;
        @(negedge clk);
        bus.iv = v;
        bus.iv_load = 1'b1;
        n = 0;
        while (!bus.iv_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check1("iv_accept", bus.iv_ready, 1'b1);
        m_load(v);
        @(negedge clk);
        bus.iv_load = 1'b0;
        wait_din_ready("load", cyc);
        check_reqs("load");
    endtask

    task automatic do_block(input logic [63:0] d, input logic [2:0] nb,
                            input int hold, output logic [63:0] got);
        logic [63:0] expd;
        int cyc;
        check1("blk_din_ready", bus.din_ready, 1'b1);
        bus.din = d;
        bus.din_valid = 1'b1;
`ifdef GAMMA_PARTIAL_EN
        bus.din_nbytes = nb;
`endif
        expd = (d ^ m_gamma) & m_mask(nb);
        @(negedge clk);
        bus.din_valid = 1'b0;
        bus.din = {$urandom, $urandom};
        check1("dout_valid", bus.dout_valid, 1'b1);
        check("dout", bus.dout, expd);
        got = bus.dout;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_dout", bus.dout, expd);
            check1("bp_pvalid", bus.core_pvalid, 1'b0);
        end
        bus.dout_ready = 1'b1;
        @(negedge clk);
        bus.dout_ready = 1'b0;
        check1("step_dvalid", bus.dout_valid, 1'b0);
        check1("step_pvalid", bus.core_pvalid, 1'b0);
        m_step();
        @(negedge clk);
        check1("gam_pvalid", bus.core_pvalid, 1'b1);
        check("gam_pdata", bus.core_pdata, {m_n4, m_n3});
        wait_din_ready("blk", cyc);
        check_reqs("blk");
    endtask

    task automatic check_idle(input string tag);
        check1({tag, "_iv_ready"}, bus.iv_ready, 1'b1);
        check1({tag, "_din_ready"}, bus.din_ready, 1'b0);
        check1({tag, "_dout_valid"}, bus.dout_valid, 1'b0);
        check1({tag, "_pvalid"}, bus.core_pvalid, 1'b0);
        check1({tag, "_cready"}, bus.core_cready, 1'b0);
        check({tag, "_dout"}, bus.dout, 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] got;
        logic [63:0] v;
        int cyc;
        int n;
        bus.iv = '0;
        bus.iv_load = 1'b0;
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.dout_ready = 1'b0;
`ifdef GAMMA_PARTIAL_EN
        bus.din_nbytes = 3'd0;
`endif
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check1("rst_async_iv_ready", bus.iv_ready, 1'b1);
        repeat (2) @(negedge clk);
        check_idle("rst");
        check1("core_mode", bus.core_mode, 1'b0);
        #2 rst_n = 1'b1;

        // zero IV through identity core
        do_load(64'd0, cyc);
        check("iv_to_din_ready_cycles", 64'(cyc), 64'd5);
        do_block(64'd0, 3'd0, 0, got);
        check("zero_blk1", got, 64'h0101010401010101);
        do_block(64'd0, 3'd0, 0, got);
        check("zero_blk2", got, 64'h0202020802020202);

        // N4 reaching 0xFFFFFFFF, then wrapping
        push_ovr(64'hFEFEFEFB_FFFFFFFF);
        do_load({$urandom, $urandom}, cyc);
        check("wrap_req1", last_req, 64'hFFFFFFFF_01010100);
        do_block({$urandom, $urandom}, 3'd0, 0, got);
        check("wrap_req2", last_req, 64'h01010104_02020201);

        // output backpressure
        do_block({$urandom, $urandom}, 3'd0, 10, got);

        // iv_load beats din_valid in GAM_READY
        v = {$urandom, $urandom};
        bus.iv = v;
        bus.iv_load = 1'b1;
        bus.din = {$urandom, $urandom};
        bus.din_valid = 1'b1;
        m_load(v);
        @(negedge clk);
        bus.iv_load = 1'b0;
        bus.din_valid = 1'b0;
        check1("prio_no_dout", bus.dout_valid, 1'b0);
        check1("prio_pvalid", bus.core_pvalid, 1'b1);
        check("prio_pdata", bus.core_pdata, v);
        wait_din_ready("prio", cyc);
        check_reqs("prio");
        do_block({$urandom, $urandom}, 3'd0, 1, got);

        // reset while holding dout
        bus.din = {$urandom, $urandom};
        bus.din_valid = 1'b1;
        @(negedge clk);
        bus.din_valid = 1'b0;
        check1("out_valid_pre_rst", bus.dout_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_idle("rst_out");
        repeat (2) @(negedge clk);
        clear_all();
        #2 rst_n = 1'b1;

        // randomized: keyed core, random handshake timing
        ekey = {$urandom, $urandom};
        pr_always = 1'b0;
        lat_max = 3;
        for (int k = 0; k < 3; k++) begin
            do_load({$urandom, $urandom}, cyc);
            for (int b = 0; b < 3; b++)
                do_block({$urandom, $urandom}, 3'($urandom_range(0, 7)),
                         $urandom_range(0, 3), got);
        end

        // reset during GAM_WAIT, then stray core results
        pr_always = 1'b1;
        lat_min = 6;
        lat_max = 6;
        @(negedge clk);
        bus.iv = {$urandom, $urandom};
        bus.iv_load = 1'b1;
        @(negedge clk);
        bus.iv_load = 1'b0;
        n = 0;
        while (reqs.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("gw_reqs_seen", 64'(reqs.size()), 64'd2);
        @(negedge clk);
        check1("gw_cready", bus.core_cready, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_idle("rst_gw");
        repeat (2) @(negedge clk);
        clear_all();
        #2 rst_n = 1'b1;
        @(negedge clk);
        inject = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_idle("late_cvalid");
        end
        inject = 1'b0;
        @(negedge clk);
        clear_all();

        // recovery after reset
        lat_min = 0;
        lat_max = 2;
        do_load({$urandom, $urandom}, cyc);
        do_block({$urandom, $urandom}, 3'd0, 0, got);

`ifdef GAMMA_PARTIAL_EN
        push_ovr({$urandom, $urandom});
        push_ovr(64'd0);
        do_load({$urandom, $urandom}, cyc);
        do_block(64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 0, got);
        check("partial3", got, 64'h0000_0000_00FF_FFFF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
